// File: rtl/rtc_pkg.sv
// Shared constants for the RTC always-on core: datapath widths and the bit positions of the
// control register fields.
package rtc_pkg;

  localparam int unsigned CNT_W = 32;  // counter, match register and write-data width
  localparam int unsigned DIV_W = 20;  // prescaler divider width
  localparam int unsigned CR_W  = 4;   // control register width

  // Control register bit positions
  localparam int unsigned CR_EN  = 0;  // count enable
  localparam int unsigned CR_IE  = 1;  // match-interrupt enable
  localparam int unsigned CR_CLR = 2;  // clear counter on match
  localparam int unsigned CR_MSK = 3;  // interrupt mask

endpackage

// File: rtl/rtc_aou_sync_edge.sv
// Two-flop synchroniser for a level strobe from a foreign clock domain, followed by a rising-edge
// detector that yields a single-cycle pulse per high level.
//   clk_i   - destination clock
//   rst_ni  - asynchronous active-low reset; clears the synchroniser and the edge history
//   level_i - asynchronous level strobe
//   pulse_o - one-cycle pulse, high in the cycle after the second synchroniser flop sees the rise
module rtc_aou_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic level_i,
  output logic pulse_o
);

  // [0],[1]: synchroniser; [2]: previous synchronised level for edge detection
  logic [2:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], level_i};
    end
  end

  assign pulse_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/rtc_aou_core.sv
// Always-on half of the RTC. Owns the control/divider/match registers, the prescaler, the
// counter and the sticky match flag, all in the rtc_clk domain.
//   rtc_clk, rtc_rst_b      - clock and asynchronous active-low reset
//   pdu_aou_wen_cr/div/mr   - pclk-domain level write strobes for CR, DIV and MR
//   pdu_aou_int_clr         - pclk-domain level strobe clearing int_flag
//   pdu_aou_wen_clr_sync    - rtc_clk-synchronous one-cycle counter-load pulse
//   pdu_aou_clr_reg         - shared write data, stable while any strobe is high
//   aou_pdu_*               - register, counter and mask read-back to the PDU side
//   int_flag                - sticky match flag
//   rtc_intr                - registered int_flag & ~CR[3] to the interrupt controller
module rtc_aou_core #(
  parameter int unsigned CNT_W = rtc_pkg::CNT_W,
  parameter int unsigned DIV_W = rtc_pkg::DIV_W,
  parameter int unsigned CR_W  = rtc_pkg::CR_W
) (
  input  logic             rtc_clk,
  input  logic             rtc_rst_b,
  input  logic             pdu_aou_wen_cr,
  input  logic             pdu_aou_wen_div,
  input  logic             pdu_aou_wen_mr,
  input  logic             pdu_aou_int_clr,
  input  logic             pdu_aou_wen_clr_sync,
  input  logic [CNT_W-1:0] pdu_aou_clr_reg,
  output logic [CR_W-1:0]  aou_pdu_cr_reg,
  output logic [DIV_W-1:0] aou_pdu_div_reg,
  output logic [CNT_W-1:0] aou_pdu_mr_reg,
  output logic [CNT_W-1:0] aou_pdu_cnt,
  output logic             aou_pdu_intr_mask,
  output logic             int_flag,
  output logic             rtc_intr
);

  import rtc_pkg::*;

  logic cr_wr, div_wr, mr_wr, int_clr;

  rtc_aou_sync_edge u_sync_cr (
    .clk_i   (rtc_clk),
    .rst_ni  (rtc_rst_b),
    .level_i (pdu_aou_wen_cr),
    .pulse_o (cr_wr)
  );

  rtc_aou_sync_edge u_sync_div (
    .clk_i   (rtc_clk),
    .rst_ni  (rtc_rst_b),
    .level_i (pdu_aou_wen_div),
    .pulse_o (div_wr)
  );

  rtc_aou_sync_edge u_sync_mr (
    .clk_i   (rtc_clk),
    .rst_ni  (rtc_rst_b),
    .level_i (pdu_aou_wen_mr),
    .pulse_o (mr_wr)
  );

  rtc_aou_sync_edge u_sync_int_clr (
    .clk_i   (rtc_clk),
    .rst_ni  (rtc_rst_b),
    .level_i (pdu_aou_int_clr),
    .pulse_o (int_clr)
  );

  logic [CR_W-1:0]  cr_q, cr_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] mr_q, mr_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flag_q, flag_d;
  logic             intr_q, intr_d;
  logic             tick, match;

  // Tick and match always see the register values from before any write landing this cycle.
  assign tick  = cr_q[CR_EN] && (presc_q == div_q);
  assign match = (cnt_q == mr_q);

  always_comb begin
    cr_d    = cr_q;
    div_d   = div_q;
    mr_d    = mr_q;
    presc_d = presc_q + DIV_W'(1);
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    intr_d  = flag_q & ~cr_q[CR_MSK];

    if (cr_wr)  cr_d  = pdu_aou_clr_reg[CR_W-1:0];
    if (div_wr) div_d = pdu_aou_clr_reg[DIV_W-1:0];
    if (mr_wr)  mr_d  = pdu_aou_clr_reg;

    if (pdu_aou_wen_clr_sync || div_wr || !cr_q[CR_EN] || tick) begin
      presc_d = '0;
    end

    if (pdu_aou_wen_clr_sync) begin
      cnt_d = pdu_aou_clr_reg;
    end else if (tick) begin
      cnt_d = (cr_q[CR_CLR] && match) ? '0 : cnt_q + CNT_W'(1);
    end

    // A match tick wins over a coincident clear so no event is lost.
    if (tick && match && cr_q[CR_IE]) begin
      flag_d = 1'b1;
    end else if (int_clr) begin
      flag_d = 1'b0;
    end
  end

  always_ff @(posedge rtc_clk or negedge rtc_rst_b) begin
    if (!rtc_rst_b) begin
      cr_q    <= '0;
      div_q   <= '0;
      mr_q    <= '0;
      presc_q <= '0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      intr_q  <= 1'b0;
    end else begin
      cr_q    <= cr_d;
      div_q   <= div_d;
      mr_q    <= mr_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      intr_q  <= intr_d;
    end
  end

  assign aou_pdu_cr_reg    = cr_q;
  assign aou_pdu_div_reg   = div_q;
  assign aou_pdu_mr_reg    = mr_q;
  assign aou_pdu_cnt       = cnt_q;
  assign aou_pdu_intr_mask = cr_q[CR_MSK];
  assign int_flag          = flag_q;
  assign rtc_intr          = intr_q;

endmodule

// File: tb/tb_rtc_aou_core.sv
module tb_rtc_aou_core;

  logic        rtc_clk = 1'b0;
  logic        rtc_rst_b = 1'b0;
  logic [3:0]  stb = '0;  // [0] CR, [1] DIV, [2] MR, [3] int_clr
  logic        clr_sync = 1'b0;
  logic [31:0] data = '0;

  logic [3:0]  cr_o;
  logic [19:0] div_o;
  logic [31:0] mr_o, cnt_o;
  logic        msk_o, flag_o, intr_o;

  always #5 rtc_clk = ~rtc_clk;

  rtc_aou_core dut (
    .rtc_clk              (rtc_clk),
    .rtc_rst_b            (rtc_rst_b),
    .pdu_aou_wen_cr       (stb[0]),
    .pdu_aou_wen_div      (stb[1]),
    .pdu_aou_wen_mr       (stb[2]),
    .pdu_aou_int_clr      (stb[3]),
    .pdu_aou_wen_clr_sync (clr_sync),
    .pdu_aou_clr_reg      (data),
    .aou_pdu_cr_reg       (cr_o),
    .aou_pdu_div_reg      (div_o),
    .aou_pdu_mr_reg       (mr_o),
    .aou_pdu_cnt          (cnt_o),
    .aou_pdu_intr_mask    (msk_o),
    .int_flag             (flag_o),
    .rtc_intr             (intr_o)
  );

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a write whose strobe is first seen high at edge e lands at edge e+2;
  // the counter advances once every DIV+1 enabled cycles.
  int          cyc = 0;
  logic [3:0]  m_cr = '0;
  logic [19:0] m_div = '0, m_phase = '0;
  logic [31:0] m_mr = '0, m_cnt = '0;
  logic        m_flag = 1'b0, m_intr = 1'b0;
  bit          m_seen [4];
  int          m_at [4];
  logic        m_tick, m_match;

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_seen[i] = 1'b0;
      m_at[i]   = -1;
    end
    forever begin
      @(posedge rtc_clk or negedge rtc_rst_b);
      if (!rtc_rst_b) begin
        m_cr = '0; m_div = '0; m_phase = '0; m_mr = '0; m_cnt = '0;
        m_flag = 1'b0; m_intr = 1'b0;
        for (int i = 0; i < 4; i++) begin
          m_seen[i] = 1'b0;
          m_at[i]   = -1;
        end
      end else begin
        cyc++;
        m_tick  = m_cr[0] && (m_phase == m_div);
        m_match = (m_cnt == m_mr);
        m_intr  = m_flag && !m_cr[3];
        if (clr_sync) m_cnt = data;
        else if (m_tick) m_cnt = (m_cr[2] && m_match) ? 32'd0 : m_cnt + 32'd1;
        if (clr_sync || m_at[1] == cyc || !m_cr[0] || m_tick) m_phase = '0;
        else m_phase = m_phase + 20'd1;
        if (m_tick && m_match && m_cr[1]) m_flag = 1'b1;
        else if (m_at[3] == cyc) m_flag = 1'b0;
        if (m_at[0] == cyc) m_cr = data[3:0];
        if (m_at[1] == cyc) m_div = data[19:0];
        if (m_at[2] == cyc) m_mr = data;
        for (int i = 0; i < 4; i++) begin
          if (m_at[i] == cyc) m_at[i] = -1;
          if (stb[i] && !m_seen[i]) m_at[i] = cyc + 2;
          m_seen[i] = stb[i];
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge rtc_clk);
      if (chk_en) begin
        chk("cr", {28'd0, cr_o}, {28'd0, m_cr});
        chk("div", {12'd0, div_o}, {12'd0, m_div});
        chk("mr", mr_o, m_mr);
        chk("cnt", cnt_o, m_cnt);
        chk("mask", {31'd0, msk_o}, {31'd0, m_cr[3]});
        chk("flag", {31'd0, flag_o}, {31'd0, m_flag});
        chk("intr", {31'd0, intr_o}, {31'd0, m_intr});
      end
    end
  end

  task automatic step();
    @(posedge rtc_clk);
    #1;
  endtask

  // Level strobe: high for 3 edges, then low for 3 edges; returns on an edge.
  task automatic strobe(input int sel, input logic [31:0] d);
    @(posedge rtc_clk);
    #1;
    data = d;
    stb[sel] = 1'b1;
    repeat (3) @(posedge rtc_clk);
    #1;
    stb[sel] = 1'b0;
    repeat (3) @(posedge rtc_clk);
  endtask

  // Counter load; returns 1 ns after the loading edge.
  task automatic load(input logic [31:0] d);
    @(posedge rtc_clk);
    #1;
    data = d;
    clr_sync = 1'b1;
    step();
    clr_sync = 1'b0;
  endtask

  // CR strobe interrupted by a reset; the strobe outlives the reset.
  task automatic reset_mid_write(input logic [31:0] d);
    @(posedge rtc_clk);
    #1;
    data = d;
    stb[0] = 1'b1;
    step();
    rtc_rst_b = 1'b0;
    repeat (2) @(posedge rtc_clk);
    #1;
    rtc_rst_b = 1'b1;
    repeat (3) @(posedge rtc_clk);
    #1;
    stb[0] = 1'b0;
    repeat (3) @(posedge rtc_clk);
  endtask

  initial begin
    @(posedge rtc_clk);
    chk_en = 1'b1;
    repeat (2) @(posedge rtc_clk);
    #1;
    rtc_rst_b = 1'b1;
    chk("lit_reset_cnt", cnt_o, 32'd0);
    chk("lit_reset_cr", {28'd0, cr_o}, 32'd0);

    // Enable with DIV = 0: CR lands 3 edges after the strobe rises, then one count per cycle
    strobe(1, 32'd0);
    strobe(0, 32'h1);
    #1;
    chk("lit_enable_cr", {28'd0, cr_o}, 32'h1);
    chk("lit_enable_cnt", cnt_o, 32'd3);

    // Load coinciding with a tick
    load(32'h100);
    chk("lit_load_tick", cnt_o, 32'h100);
    step();
    chk("lit_load_next", cnt_o, 32'h101);

    // Wrap-around with MR = 0 and CR[1] clear
    load(32'hFFFF_FFFE);
    chk("lit_wrap0", cnt_o, 32'hFFFF_FFFE);
    step();
    chk("lit_wrap1", cnt_o, 32'hFFFF_FFFF);
    step();
    chk("lit_wrap2", cnt_o, 32'h0);
    chk("lit_wrap_flag", {31'd0, flag_o}, 32'd0);

    // Divider of 4: one count every 5 cycles
    strobe(1, 32'd4);
    load(32'd0);
    repeat (4) step();
    chk("lit_div_hold", cnt_o, 32'd0);
    step();
    chk("lit_div_1", cnt_o, 32'd1);
    repeat (5) step();
    chk("lit_div_2", cnt_o, 32'd2);
    strobe(1, 32'd4);

    // Match with clear-on-match
    strobe(0, 32'h0);
    strobe(1, 32'd0);
    strobe(2, 32'd3);
    load(32'd0);
    strobe(0, 32'h7);
    #1;
    chk("lit_match_pre_cnt", cnt_o, 32'd3);
    chk("lit_match_pre_flag", {31'd0, flag_o}, 32'd0);
    step();
    chk("lit_match_cnt", cnt_o, 32'd0);
    chk("lit_match_flag", {31'd0, flag_o}, 32'd1);
    chk("lit_match_intr0", {31'd0, intr_o}, 32'd0);
    step();
    chk("lit_match_intr1", {31'd0, intr_o}, 32'd1);

    // Mask: flag stays, interrupt drops
    strobe(0, 32'hF);
    #1;
    chk("lit_mask_flag", {31'd0, flag_o}, 32'd1);
    chk("lit_mask_intr", {31'd0, intr_o}, 32'd0);

    // Stop, then clear the flag
    strobe(0, 32'h2);
    strobe(3, 32'd0);
    #1;
    chk("lit_clr_flag", {31'd0, flag_o}, 32'd0);

    // int_clr landing on a match tick: the flag must stay set
    load(32'h50);
    strobe(0, 32'h7);
    #1;
    data = 32'd1;
    clr_sync = 1'b1;
    step();
    clr_sync = 1'b0;
    stb[3] = 1'b1;
    repeat (2) step();
    chk("lit_coll_pre_cnt", cnt_o, 32'd3);
    chk("lit_coll_pre_flag", {31'd0, flag_o}, 32'd0);
    step();
    chk("lit_coll_flag", {31'd0, flag_o}, 32'd1);
    stb[3] = 1'b0;
    repeat (3) step();

    // Randomised traffic, checked every cycle against the model
    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 7))
        0: strobe(0, 32'($urandom_range(0, 15)));
        1: strobe(1, 32'($urandom_range(0, 6)));
        2: strobe(2, 32'($urandom_range(0, 12)));
        3: strobe(3, $urandom);
        4: load(($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 12))
                                            : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)));
        5: repeat ($urandom_range(1, 12)) @(posedge rtc_clk);
        6: reset_mid_write(32'($urandom_range(0, 15)));
        default: strobe(1, 32'($urandom_range(0, 30)));
      endcase
    end

    repeat (5) @(posedge rtc_clk);
    #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rtc_aou_core.md
# rtc_aou_core

Always-on (AOU) half of the RTC and the far end of the PDU/AOU crossing. It runs on `rtc_clk` and owns the RTC state:
- the control, divider and match registers;
- the 20-bit prescaler and the 32-bit counter;
- the match interrupt flag.

Register writes arrive from the power-down APB front end as level strobes in the `pclk` domain. This block synchronises them into `rtc_clk` and applies them. Register contents, count and flag are returned to the PDU side as `aou_pdu_*` signals.

## Interface
Parameters:
- CNT_W, 32, counter, match and write-data width.
- DIV_W, 20, prescaler divider width.
- CR_W, 4, control register width.

Ports:
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
  - rtc_clk  in  1  sole clock.
  - rtc_rst_b  in  1  asynchronous, active-low reset.
- Write strobes from the PDU side:
  - pdu_aou_wen_cr  in  1  CR write strobe; `pclk`-domain level.
  - pdu_aou_wen_div  in  1  DIV write strobe; `pclk`-domain level.
  - pdu_aou_wen_mr  in  1  MR write strobe; `pclk`-domain level.
  - pdu_aou_int_clr  in  1  interrupt-clear strobe; `pclk`-domain level.
  - pdu_aou_wen_clr_sync  in  1  counter-load pulse, already synchronous to `rtc_clk`, one cycle wide.
  - pdu_aou_clr_reg  in  32  shared write data for all writes; held stable by the PDU while any strobe is high.
- Read-back to the PDU side:
  - aou_pdu_cr_reg  out  4  control register.
  - aou_pdu_div_reg  out  20  divider register.
  - aou_pdu_mr_reg  out  32  match register.
  - aou_pdu_cnt  out  32  counter.
  - aou_pdu_intr_mask  out  1  equals CR[3].
  - int_flag  out  1  sticky match flag.
- rtc_intr  out  1  `int_flag & ~CR[3]`, registered; goes to the interrupt controller.

## Operation
- **Control register bits:**
  - CR[0] count enable.
  - CR[1] match-interrupt enable.
  - CR[2] clear-on-match.
  - CR[3] interrupt mask.
- **Strobe capture:** each `pclk`-domain strobe goes through a 2-flop synchroniser followed by rising-edge detect. On a detected edge, the target register is written:
  - CR ← data[3:0].
  - DIV ← data[19:0].
  - MR ← data[31:0].
  - int_clr clears `int_flag`.
- **PDU obligation on strobes:** hold each strobe high, and the data stable, for at least 3 `rtc_clk` periods. Drop the strobe low for at least 3 periods before the next one. A held-high strobe produces exactly one write.
- **Prescaler:**
  - While CR[0] is set, `presc` counts 0..DIV. `tick` is asserted in the cycle where `presc == DIV`, and `presc` returns to 0 on that cycle.
  - DIV = 0 gives a tick every cycle.
  - While CR[0] is clear, `presc` is held at 0 and no ticks occur.
- **Counter update on tick:**
  - If CR[2] is set and `cnt == MR`: `cnt ← 0`.
  - Otherwise: `cnt ← cnt + 1`, modulo 2^32 (0xFFFFFFFF wraps to 0).
- **Match flag:** on a tick with `cnt == MR` and CR[1] set, `int_flag ← 1`. The flag stays set until int_clr.
- **Counter load:** `pdu_aou_wen_clr_sync` loads `cnt ← pdu_aou_clr_reg` and sets `presc ← 0`. A load does not set the flag.
- **DIV write:** also sets `presc ← 0`.
- **Priority, highest first:** load > tick for `cnt`; flag set > int_clr in the same cycle.
- **Register writes vs. counting:** a CR/DIV/MR write coinciding with a tick takes effect from the next cycle. The tick uses the old values.

## Timing
- **Reset values:** all outputs and internal state are 0. CR = 0 means the counter is stopped.
- **Write latency:** a strobe that rises before rtc_clk edge k is applied at edge k+2; the register output changes after edge k+2. Synchroniser flops are at edges k and k+1; the update happens at k+2.
- **Load latency:** the load is applied at the first edge where `wen_clr_sync` is high. `aou_pdu_cnt` is valid in the next cycle.
- **Counting rate:** `cnt` advances once every (DIV+1) cycles. The first tick after enable comes DIV+1 cycles after the CR write lands.
- **rtc_intr:** lags `int_flag` by one cycle.
- **Reset asserted mid-write:** the synchronisers clear. A strobe still high after reset release produces a fresh write, because the edge detect sees 0→1.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- **Package `rtc_pkg`:**
  - CR bit index constants: CR_EN = 0, CR_IE = 1, CR_CLR = 2, CR_MSK = 3.
  - Widths CNT_W, DIV_W and CR_W.
- **Sub-module `rtc_aou_sync_edge`:** 2-flop synchroniser plus rising-edge pulse. Four instances: CR, DIV, MR, int_clr.
- Prescaler, counter, registers and flag live inline in `rtc_aou_core`.

## Test plan
- **Reset and enable:** release reset, then write CR = 0x1 with DIV = 0. Expect `cnt` = 0, 1, 2, … on consecutive cycles, and the CR write visible 3 edges after the strobe rises.
- **Divider:** DIV = 4, CR = 0x1. Expect `cnt` to increment every 5 cycles. Write DIV mid-count and expect the prescaler to restart from 0.
- **Match with clear-on-match:** MR = 3, CR = 0x7. Expect `cnt` sequence 0, 1, 2, 3, 0, 1, …, `int_flag` set on the 3→0 tick, and `rtc_intr` one cycle later.
- **Mask, clear, collision:**
  - CR = 0xF: `int_flag` sets but `rtc_intr` stays 0.
  - int_clr: clears the flag.
  - int_clr landing in the same cycle as a match tick: the flag stays 1.
- **Wrap-around:** load 0xFFFFFFFE, CR = 0x1. Expect 0xFFFFFFFF then 0x00000000, with no flag when MR = 0 and CR[1] = 0.
- **Load vs tick:** `wen_clr_sync` with data 0x100 in a tick cycle. Expect `cnt` = 0x100 next cycle (no increment) and the prescaler restarted.
